// File: rtl/split_case_sched.sv
// Four-channel one-byte-deep feeder for the 4-way registered case-select stage.
// Round-robin arbitration with a burst limit; dN_w snapshots change only for the granted channel.
module split_case_sched #(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input  logic                clk_w,
  input  logic                rst_n_w,
  input  logic [3:0]          in_vld_w,
  input  logic [4*DATA_W-1:0] in_data_w,
  output logic [3:0]          in_rdy_w,
  input  logic                dn_rdy_w,
  output logic [DATA_W-1:0]   d0_w,
  output logic [DATA_W-1:0]   d1_w,
  output logic [DATA_W-1:0]   d2_w,
  output logic [DATA_W-1:0]   d3_w,
  output logic [1:0]          sel_w,
  output logic                sel_vld_w
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  logic [DATA_W-1:0] data_q [4];
  logic [DATA_W-1:0] dout_q [4];
  logic [3:0]        full_q;
  logic [1:0]        sel_q;
  logic              sel_vld_q;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d, cnt_inc;
  logic [1:0]        prev_q;

  logic              gnt_vld;
  logic [1:0]        gnt_idx;
  logic [3:0]        pop;

  // Scan offsets high to low so the nearest full channel after ptr wins.
  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + k[1:0];
      if (full_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (!dn_rdy_w) gnt_vld = 1'b0;
  end

  assign pop      = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
  assign in_rdy_w = ~full_q | pop;

  always_comb begin
    cnt_inc = (gnt_idx == prev_q && cnt_q != 4'd0) ? cnt_q + 4'd1 : 4'd1;
    if (cnt_inc == BURST_L) begin
      ptr_d = gnt_idx + 2'd1;
      cnt_d = 4'd0;
    end else begin
      ptr_d = gnt_idx;
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      full_q    <= '0;
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      // A pop and an accept in the same cycle keep the buffer full with the new byte.
      for (int k = 0; k < 4; k++) begin
        if (in_vld_w[k] && in_rdy_w[k]) begin
          data_q[k] <= in_data_w[k*DATA_W +: DATA_W];
          full_q[k] <= 1'b1;
        end else if (pop[k]) begin
          full_q[k] <= 1'b0;
        end
      end
      sel_vld_q <= gnt_vld;
      if (gnt_vld) begin
        dout_q[gnt_idx] <= data_q[gnt_idx];
        sel_q           <= gnt_idx;
        prev_q          <= gnt_idx;
        ptr_q           <= ptr_d;
        cnt_q           <= cnt_d;
      end
    end
  end

  assign d0_w      = dout_q[0];
  assign d1_w      = dout_q[1];
  assign d2_w      = dout_q[2];
  assign d3_w      = dout_q[3];
  assign sel_w     = sel_q;
  assign sel_vld_w = sel_vld_q;

endmodule

// File: tb/tb_split_case_sched.sv
// Directed bench for split_case_sched: vector table plus hand-written burst, stall and reset sequences.
module tb_split_case_sched;

  logic        clk_w = 1'b0;
  logic        rst_n_w = 1'b1;
  logic [3:0]  in_vld_w = 4'b0;
  logic [31:0] in_data_w = 32'h0;
  logic        dn_rdy_w = 1'b0;
  logic [3:0]  in_rdy_w, in_rdy1_w;
  logic [7:0]  d0_w, d1_w, d2_w, d3_w, e0_w, e1_w, e2_w, e3_w;
  logic [1:0]  sel_w, sel1_w;
  logic        sel_vld_w, sel_vld1_w;
  logic [31:0] dcat, ecat;

  int errors = 0;
  int checks = 0;

  always #5 clk_w = ~clk_w;

  split_case_sched #(.DATA_W(8), .BURST(4)) dut (
    .clk_w(clk_w), .rst_n_w(rst_n_w), .in_vld_w(in_vld_w), .in_data_w(in_data_w),
    .in_rdy_w(in_rdy_w), .dn_rdy_w(dn_rdy_w), .d0_w(d0_w), .d1_w(d1_w), .d2_w(d2_w),
    .d3_w(d3_w), .sel_w(sel_w), .sel_vld_w(sel_vld_w)
  );

  split_case_sched #(.DATA_W(8), .BURST(1)) dut_rr (
    .clk_w(clk_w), .rst_n_w(rst_n_w), .in_vld_w(in_vld_w), .in_data_w(in_data_w),
    .in_rdy_w(in_rdy1_w), .dn_rdy_w(dn_rdy_w), .d0_w(e0_w), .d1_w(e1_w), .d2_w(e2_w),
    .d3_w(e3_w), .sel_w(sel1_w), .sel_vld_w(sel_vld1_w)
  );

  assign dcat = {d3_w, d2_w, d1_w, d0_w};
  assign ecat = {e3_w, e2_w, e1_w, e0_w};

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        dn;
    logic [3:0]  rdy;
    logic        sv;
    logic [1:0]  sel;
    logic [31:0] d;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  task automatic do_reset();
    rst_n_w   = 1'b0;
    in_vld_w  = 4'b0;
    in_data_w = 32'h0;
    dn_rdy_w  = 1'b1;
    tick();
    tick();
    @(negedge clk_w);
    rst_n_w = 1'b1;
    tick();
  endtask

  task automatic apply(input int i);
    in_vld_w  = tbl[i].vld;
    in_data_w = tbl[i].data;
    dn_rdy_w  = tbl[i].dn;
    #1;
    chk("vec_in_rdy", 32'(in_rdy_w), 32'(tbl[i].rdy));
    @(posedge clk_w);
    #1;
    chk("vec_sel_vld", 32'(sel_vld_w), 32'(tbl[i].sv));
    chk("vec_sel", 32'(sel_w), 32'(tbl[i].sel));
    chk("vec_dN", dcat, tbl[i].d);
    $display("vec %0d: rdy=%b sel_vld=%0b sel=%0d d=%h", i, in_rdy_w, sel_vld_w, sel_w, dcat);
  endtask

  initial begin
    logic [7:0] ch2_seq [8];
    logic [7:0] exp_dat [7];
    logic [1:0] exp_sel [7];
    int esel;

    // {vld, data, dn, exp in_rdy (before edge), exp sel_vld, exp sel, exp {d3,d2,d1,d0}}
    tbl[0]  = '{4'b0001, 32'h0000_00A5, 1'b1, 4'b1111, 1'b0, 2'd0, 32'h0000_0000};
    tbl[1]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b1111, 1'b1, 2'd0, 32'h0000_00A5};
    tbl[2]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b1111, 1'b0, 2'd0, 32'h0000_00A5};
    tbl[3]  = '{4'b1111, 32'h4433_2211, 1'b0, 4'b1111, 1'b0, 2'd0, 32'h0000_00A5};
    for (int i = 4; i <= 8; i++)
      tbl[i] = '{4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0000_00A5};
    tbl[9]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0011};
    tbl[10] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0011, 1'b1, 2'd1, 32'h0000_2211};
    tbl[11] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0111, 1'b1, 2'd2, 32'h0033_2211};
    tbl[12] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b1111, 1'b1, 2'd3, 32'h4433_2211};
    tbl[13] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b1111, 1'b0, 2'd3, 32'h4433_2211};

    #1 rst_n_w = 1'b0;
    @(posedge clk_w);
    #1;
    chk("reset_sel_vld", 32'(sel_vld_w), 32'h0);
    chk("reset_sel", 32'(sel_w), 32'h0);
    chk("reset_dN", dcat, 32'h0);
    chk("reset_in_rdy", 32'(in_rdy_w), 32'hF);
    @(negedge clk_w);
    rst_n_w = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) apply(i);

    // Four channels streaming: BURST=4 on dut, BURST=1 on dut_rr.
    do_reset();
    in_vld_w  = 4'b1111;
    in_data_w = 32'h1312_1110;
    tick();
    chk("stream_first_edge_vld", 32'(sel_vld_w), 32'h0);
    for (int k = 0; k < 18; k++) begin
      tick();
      esel = (k / 4) % 4;
      chk("stream_b4_vld", 32'(sel_vld_w), 32'h1);
      chk("stream_b4_sel", 32'(sel_w), 32'(esel));
      chk("stream_b4_data", 32'(dcat[esel*8 +: 8]), 32'(8'h10 + esel));
      esel = k % 4;
      chk("stream_b1_sel", 32'(sel1_w), 32'(esel));
      chk("stream_b1_data", 32'(ecat[esel*8 +: 8]), 32'(8'h10 + esel));
      $display("stream %0d: b4 sel=%0d b1 sel=%0d", k, sel_w, sel1_w);
    end

    // Burst interruption: ch0 valid two cycles while ch2 streams.
    do_reset();
    ch2_seq = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    exp_sel = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    exp_dat = '{8'hC0, 8'hC1, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    for (int e = 0; e < 8; e++) begin
      in_vld_w  = (e < 2) ? 4'b0101 : 4'b0100;
      in_data_w = {8'h00, ch2_seq[e], 8'h00, (e == 0) ? 8'hC0 : 8'hC1};
      tick();
      if (e == 0) begin
        chk("intr_first_vld", 32'(sel_vld_w), 32'h0);
      end else begin
        chk("intr_vld", 32'(sel_vld_w), 32'h1);
        chk("intr_sel", 32'(sel_w), 32'(exp_sel[e-1]));
        chk("intr_data", 32'(dcat[exp_sel[e-1]*8 +: 8]), 32'(exp_dat[e-1]));
      end
      $display("intr %0d: sel_vld=%0b sel=%0d d=%h", e, sel_vld_w, sel_w, dcat);
    end

    // Reset mid-burst with ch1 granted and three buffers full.
    do_reset();
    in_vld_w  = 4'b1110;
    in_data_w = 32'h2322_2100;
    tick();
    tick();
    chk("rstmid_pre_sel", 32'(sel_w), 32'h1);
    chk("rstmid_pre_d1", 32'(d1_w), 32'h21);
    #2;
    rst_n_w  = 1'b0;
    in_vld_w = 4'b0000;
    #1;
    chk("rstmid_async_vld", 32'(sel_vld_w), 32'h0);
    chk("rstmid_async_sel", 32'(sel_w), 32'h0);
    chk("rstmid_async_dN", dcat, 32'h0);
    chk("rstmid_async_rdy", 32'(in_rdy_w), 32'hF);
    $display("rstmid: async reset applied, sel_vld=%0b d=%h", sel_vld_w, dcat);
    @(negedge clk_w);
    rst_n_w = 1'b1;
    tick();
    chk("rstmid_idle_vld", 32'(sel_vld_w), 32'h0);
    in_vld_w  = 4'b0011;
    in_data_w = 32'h0000_B1B0;
    tick();
    in_vld_w = 4'b0000;
    chk("rstmid_accept_vld", 32'(sel_vld_w), 32'h0);
    tick();
    chk("rstmid_first_sel", 32'(sel_w), 32'h0);
    chk("rstmid_first_d0", 32'(d0_w), 32'hB0);
    tick();
    chk("rstmid_second_sel", 32'(sel_w), 32'h1);
    chk("rstmid_second_d1", 32'(d1_w), 32'hB1);
    $display("rstmid: resumed sel=%0d d=%h", sel_w, dcat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/split_case_sched.md
Name: split_case_sched

Overview:
- Upstream feeder for the 4-way registered case-select stage (8-bit data, 2-bit select, one-cycle select-to-output latency).
- Accepts four independent 8-bit producer streams with valid/ready, buffers one byte per channel, and arbitrates between channels round-robin with a configurable burst limit.
- Drives the stage's d0_w..d3_w and sel_w so each issued byte appears at the stage output exactly one clock after issue.

Parameters:
- DATA_W, 8, data width per channel; must match the select stage.
- BURST, 4, max consecutive grants to one channel before priority moves on; legal range 1..15; 1 = pure round-robin.

Ports:
- clk_w  input  1  clock, rising edge.
- rst_n_w  input  1  asynchronous, active-low reset.
- in_vld_w  input  4  per-channel valid; bit i = channel i.
- in_data_w  input  4*DATA_W  packed channel data; channel i at [i*DATA_W +: DATA_W].
- in_rdy_w  output  4  per-channel ready.
- dn_rdy_w  input  1  downstream enable; 0 stalls issue.
- d0_w, d1_w, d2_w, d3_w  output  DATA_W each  snapshot data to the select stage.
- sel_w  output  2  channel select to the select stage.
- sel_vld_w  output  1  1 = sel_w/dN_w carry a new byte this cycle.

Behaviour:
- Reset, asynchronous on rst_n_w low:
  - All buffer-full flags = 0.
  - d0_w..d3_w = 0, sel_w = 0, sel_vld_w = 0.
  - Priority pointer ptr = 0, burst count cnt = 0, prev grant = 0.
  - Buffered bytes are discarded on reset mid-operation. Outputs stay at reset values until the first grant after release.
- Per-channel buffer: one DATA_W entry plus full[i].
  - in_rdy_w[i] = !full[i] | pop[i]. This is combinational, so a channel can stream one byte per clock.
  - Accept when in_vld_w[i] & in_rdy_w[i]: buf[i] <= data, full[i] <= 1.
  - Pop without accept: full[i] <= 0.
  - Pop and accept in the same cycle: full[i] stays 1 and buf[i] takes the new byte.
- Grant (combinational):
  - Issue only if dn_rdy_w = 1 and any full[i] = 1.
  - g = first full channel searching ptr, ptr+1, ... modulo 4.
  - pop[g] = 1. No grant when dn_rdy_w = 0 or all buffers are empty.
- Issue registers, on the clock edge of a grant:
  - dg_w <= buf[g]; the other dN_w hold their values.
  - sel_w <= g; sel_vld_w <= 1.
  - Without a grant: sel_vld_w <= 0 and sel_w and dN_w hold.
  - Snapshot rule: dN_w changes only when channel N is granted. This keeps the select stage consistent when it samples sel_w/dN_w on the next edge, even if buf[g] is refilled in the same cycle.
- Latency:
  - Byte accepted at edge k is issued at edge ≥ k+1.
  - The select stage presents it at edge issue+1.
  - Minimum accept-to-stage-output latency = 2 clocks.
- Burst / round-robin:
  - cnt_next = (g == prev && cnt != 0) ? cnt+1 : 1.
  - If cnt_next == BURST: ptr <= g+1 (mod 4) and cnt <= 0.
  - Otherwise: ptr <= g and cnt <= cnt_next.
  - prev <= g. ptr and cnt are unchanged on cycles without a grant.
  - ptr wraps 3 → 0.
- Stall: dn_rdy_w = 0 freezes all grants. Buffers that are already full deassert in_rdy_w; producers hold.
- Fairness: a continuously valid channel is granted within 3*BURST+1 issuing cycles.

Test Plan:
- Reset then single byte: in_vld_w=0001, data 0xA5 at edge 1 → at edge 2 sel_w=0, d0_w=0xA5, sel_vld_w=1 for 1 cycle; in_rdy_w[0] stays 1.
- All four streaming, BURST=1, ch i sends 0x10+i repeatedly → sel_w sequence 0,1,2,3,0,… with dN_w=0x10+N on issue; sel_vld_w continuously 1.
- All four streaming, BURST=4 → sel_w = 0,0,0,0,1,1,1,1,2,… then wraps 3→0; cnt resets at each switch.
- Burst interruption: ch0 valid 2 cycles only while ch2 streams, BURST=4 → grants 0,0,2,2,2,2,0/next full; ptr resumes correctly with no lost bytes.
- Stall: all buffers full, dn_rdy_w=0 for 5 cycles → sel_vld_w=0, in_rdy_w=0000, dN_w held; dn_rdy_w=1 → issue resumes from ptr, no byte dropped or duplicated.
- Reset mid-burst: assert rst_n_w=0 while ch1 granted with 3 buffers full → outputs zero immediately (async), full cleared; after release first grant searches from ch0.
